// File: rtl/detector_victoria_seq.sv
// Sequential N-in-a-row detector: snapshots a board, scans one anchor cell per cycle
// in row-major order and reports the first winning line, or a draw when the board is full.
// tablero is flattened: cell (f,c) occupies bits [2*(f*COLUMNAS+c) +: 2].
// estado exposes the FSM state (0 REPOSO, 1 ESCANEO, 2 FIN) for observation.
module detector_victoria_seq #(
  parameter int FILAS    = 6,
  parameter int COLUMNAS = 7,
  parameter int N_LINEA  = 4,
  localparam int NC = FILAS * COLUMNAS,
  localparam int BW = 2 * NC,
  localparam int FW = (FILAS > 1) ? $clog2(FILAS) : 1,
  localparam int CW = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1,
  localparam int KW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] tablero,
  input  logic          inicio,
  output logic          ocupado,
  output logic          listo,
  output logic          hay_ganador,
  output logic [1:0]    jugador_ganador,
  output logic          empate,
  output logic [FW-1:0] fila_ganadora,
  output logic [CW-1:0] col_ganadora,
  output logic [1:0]    direccion,
  output logic [1:0]    estado
);

  typedef enum logic [1:0] {REPOSO = 2'd0, ESCANEO = 2'd1, FIN = 2'd2} estado_t;

  localparam logic [KW-1:0] K_ULT = KW'(NC - 1);
  localparam logic [CW-1:0] C_ULT = CW'(COLUMNAS - 1);

  estado_t       state_q, state_d;
  logic [BW-1:0] snap_q, snap_d;
  logic [KW-1:0] k_q, k_d;
  logic [FW-1:0] f_q, f_d;
  logic [CW-1:0] c_q, c_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic          gan_q, gan_d;
  logic [1:0]    jug_q, jug_d;
  logic          emp_q, emp_d;
  logic [FW-1:0] fila_q, fila_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    dir_q, dir_d;

  logic [3:0]    m;
  logic [1:0]    v_anchor;
  logic [1:0]    dir_hit;
  logic          lleno;

  // Cells outside the board read as empty so they can never complete a line.
  function automatic logic [1:0] celda(input int r, input int cc);
    if (r < 0 || r >= FILAS || cc < 0 || cc >= COLUMNAS) return 2'd0;
    return snap_q[2*(r*COLUMNAS+cc) +: 2];
  endfunction

  function automatic logic linea(input int r, input int cc, input int dr, input int dc);
    logic [1:0] v0;
    logic       ok;
    v0 = celda(r, cc);
    ok = (v0 == 2'd1) || (v0 == 2'd2);
    for (int i = 1; i < N_LINEA; i++) begin
      if (celda(r + i*dr, cc + i*dc) != v0) ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    m[0]     = linea(int'(f_q), int'(c_q), 0, 1);
    m[1]     = linea(int'(f_q), int'(c_q), 1, 0);
    m[2]     = linea(int'(f_q), int'(c_q), 1, 1);
    m[3]     = linea(int'(f_q), int'(c_q), 1, -1);
    v_anchor = celda(int'(f_q), int'(c_q));
    if (m[0])      dir_hit = 2'd0;
    else if (m[1]) dir_hit = 2'd1;
    else if (m[2]) dir_hit = 2'd2;
    else           dir_hit = 2'd3;
    lleno = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (snap_q[2*i +: 2] == 2'd0 || snap_q[2*i +: 2] == 2'd3) lleno = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    k_d       = k_q;
    f_d       = f_q;
    c_d       = c_q;
    ocupado_d = 1'b0;
    listo_d   = 1'b0;
    gan_d     = gan_q;
    jug_d     = jug_q;
    emp_d     = emp_q;
    fila_d    = fila_q;
    col_d     = col_q;
    dir_d     = dir_q;
    case (state_q)
      REPOSO: begin
        if (inicio) begin
          snap_d    = tablero;
          k_d       = '0;
          f_d       = '0;
          c_d       = '0;
          state_d   = ESCANEO;
          ocupado_d = 1'b1;
        end
      end
      ESCANEO: begin
        if (m != 4'd0) begin
          gan_d   = 1'b1;
          jug_d   = v_anchor;
          emp_d   = 1'b0;
          fila_d  = f_q;
          col_d   = c_q;
          dir_d   = dir_hit;
          state_d = FIN;
          listo_d = 1'b1;
        end else if (k_q == K_ULT) begin
          gan_d   = 1'b0;
          jug_d   = 2'd0;
          emp_d   = lleno;
          fila_d  = '0;
          col_d   = '0;
          dir_d   = 2'd0;
          state_d = FIN;
          listo_d = 1'b1;
        end else begin
          // Row/column track k so the anchor coordinates need no divider.
          k_d       = k_q + KW'(1);
          ocupado_d = 1'b1;
          if (c_q == C_ULT) begin
            c_d = '0;
            f_d = f_q + FW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      FIN: state_d = REPOSO;
      default: state_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REPOSO;
      snap_q    <= '0;
      k_q       <= '0;
      f_q       <= '0;
      c_q       <= '0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      gan_q     <= 1'b0;
      jug_q     <= 2'd0;
      emp_q     <= 1'b0;
      fila_q    <= '0;
      col_q     <= '0;
      dir_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      k_q       <= k_d;
      f_q       <= f_d;
      c_q       <= c_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      gan_q     <= gan_d;
      jug_q     <= jug_d;
      emp_q     <= emp_d;
      fila_q    <= fila_d;
      col_q     <= col_d;
      dir_q     <= dir_d;
    end
  end

  assign ocupado         = ocupado_q;
  assign listo           = listo_q;
  assign hay_ganador     = gan_q;
  assign jugador_ganador = jug_q;
  assign empate          = emp_q;
  assign fila_ganadora   = fila_q;
  assign col_ganadora    = col_q;
  assign direccion       = dir_q;
  assign estado          = state_q;

endmodule
